phys_frame_controller: RTL and testbench

PHYS_FRAME_CONTROLLER -- requirements
Module: phys_frame_controller

---
 rtl/phys_frame_controller.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_phys_frame_controller.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phys_frame_controller.sv
// phys_frame_controller
// Sequences one physics frame over an object register file:
//   IDLE -> LOADING (batched BRAM reads) -> COLLISION <-> UPDATING -> SAVING -> IDLE
// Frame time starts at 1.0 (1 << TIME_DEC). Each iteration queries the collision
// engine for the time to the earliest collision and advances the update engine
// by that step, clamped to the remaining time. The last allowed iteration
// consumes whatever time is left.
//
// Ports
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   frame_start_in              frame request (accepted in IDLE only)
//   state_out                   IDLE=0 LOADING=1 COLLISION=2 UPDATING=3 SAVING=4
//   frame_end_out               one-cycle pulse on return to IDLE
//   overrun_out                 one-cycle pulse: frame_start_in seen while busy
//   iter_count_out              iterations of the current/last frame
//   load_signal_out/_index_out  per-lane read strobe and 10-bit index
//   load_object_data_in         per-lane read data, MEM_LATENCY cycles after issue
//   coll_req_out/coll_ack_in    collision query; coll_dt_in sampled with the ack
//   objects_out                 object register file
//   upd_start_out/upd_dt_out    update start pulse and time step
//   upd_done_in/upd_objects_in  update completion and updated objects
//   save_signal_out/_index_out/_data_out  write-back of non-static objects
//
// Handshakes: coll_req_out rises on COLLISION entry and stays high up to and
// including the cycle in which coll_ack_in=1; that cycle's coll_dt_in is used.
// upd_start_out is high for the first UPDATING cycle only; upd_done_in counts
// only in later UPDATING cycles. Acks/dones in any other cycle are ignored.
module phys_frame_controller #(
  parameter int OBJ_COUNT   = 8,
  parameter int OBJ_WIDTH   = 103,
  parameter int LOAD_LANES  = 4,
  parameter int MEM_LATENCY = 2,
  parameter int MAX_ITER    = 64,
  parameter int TIME_W      = 32,
  parameter int TIME_DEC    = 11,
  parameter int STATIC_BIT  = 0
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst_n,
  input  logic                            frame_start_in,
  output logic [2:0]                      state_out,
  output logic                            frame_end_out,
  output logic                            overrun_out,
  output logic [7:0]                      iter_count_out,
  output logic [LOAD_LANES-1:0]           load_signal_out,
  output logic [LOAD_LANES*10-1:0]        load_object_index_out,
  input  logic [LOAD_LANES*OBJ_WIDTH-1:0] load_object_data_in,
  output logic                            coll_req_out,
  input  logic                            coll_ack_in,
  input  logic [TIME_W-1:0]               coll_dt_in,
  output logic [OBJ_COUNT*OBJ_WIDTH-1:0]  objects_out,
  output logic                            upd_start_out,
  output logic [TIME_W-1:0]               upd_dt_out,
  input  logic                            upd_done_in,
  input  logic [OBJ_COUNT*OBJ_WIDTH-1:0]  upd_objects_in,
  output logic                            save_signal_out,
  output logic [9:0]                      save_object_index_out,
  output logic [OBJ_WIDTH-1:0]            save_object_data_out
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOADING   = 3'd1,
    S_COLLISION = 3'd2,
    S_UPDATING  = 3'd3,
    S_SAVING    = 3'd4
  } state_t;

  localparam logic [TIME_W-1:0] TIME_ONE   = {{(TIME_W-1){1'b0}}, 1'b1};
  localparam logic [TIME_W-1:0] FRAME_TIME = TIME_ONE << TIME_DEC;

  state_t                           state_q, state_d;
  logic [TIME_W-1:0]                left_q, left_d;
  logic [7:0]                       iter_q, iter_d;
  logic [10:0]                      base_q, base_d;
  logic [3:0]                       lat_q, lat_d;
  logic [OBJ_COUNT*OBJ_WIDTH-1:0]   objects_q, objects_d;
  logic [LOAD_LANES-1:0]            load_sig_q, load_sig_d;
  logic [LOAD_LANES*10-1:0]         load_idx_q, load_idx_d;
  logic                             coll_req_q, coll_req_d;
  logic                             upd_start_q, upd_start_d;
  logic [TIME_W-1:0]                upd_dt_q, upd_dt_d;
  logic [9:0]                       save_ptr_q, save_ptr_d;
  logic                             save_sig_q, save_sig_d;
  logic [9:0]                       save_idx_q, save_idx_d;
  logic [OBJ_WIDTH-1:0]             save_data_q, save_data_d;
  logic                             frame_end_q, frame_end_d;
  logic                             overrun_q, overrun_d;

  // Combinational temporaries
  logic                             save_emit;
  logic [OBJ_WIDTH-1:0]             save_rec;
  logic [TIME_W-1:0]                dt_floor;
  logic [TIME_W-1:0]                step;
  logic [TIME_W-1:0]                left_next;

  // Lanes past the end of the object list stay idle with index 0.
  function automatic logic [LOAD_LANES-1:0] lane_strobes(input logic [10:0] base);
    lane_strobes = '0;
    for (int k = 0; k < LOAD_LANES; k++) begin
      if (int'(base) + k < OBJ_COUNT) lane_strobes[k] = 1'b1;
    end
  endfunction

  function automatic logic [LOAD_LANES*10-1:0] lane_indices(input logic [10:0] base);
    lane_indices = '0;
    for (int k = 0; k < LOAD_LANES; k++) begin
      if (int'(base) + k < OBJ_COUNT) lane_indices[k*10 +: 10] = 10'(int'(base) + k);
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    iter_d      = iter_q;
    base_d      = base_q;
    lat_d       = lat_q;
    objects_d   = objects_q;
    load_sig_d  = '0;
    load_idx_d  = '0;
    coll_req_d  = coll_req_q;
    upd_start_d = 1'b0;
    upd_dt_d    = upd_dt_q;
    save_ptr_d  = save_ptr_q;
    save_sig_d  = 1'b0;
    save_idx_d  = '0;
    save_data_d = '0;
    frame_end_d = 1'b0;
    overrun_d   = frame_start_in && (state_q != S_IDLE);
    save_emit   = 1'b0;
    save_rec    = '0;
    dt_floor    = '0;
    step        = '0;
    left_next   = '0;

    case (state_q)
      S_IDLE: begin
        if (frame_start_in) begin
          left_d     = FRAME_TIME;
          iter_d     = '0;
          base_d     = '0;
          lat_d      = 4'(MEM_LATENCY);
          load_sig_d = lane_strobes(11'd0);
          load_idx_d = lane_indices(11'd0);
          state_d    = S_LOADING;
        end
      end

      S_LOADING: begin
        // lat_q counts down from MEM_LATENCY in the issue cycle, so it reaches
        // zero exactly in the cycle the read data is valid.
        if (lat_q != 4'd0) begin
          lat_d = lat_q - 4'd1;
        end else begin
          for (int i = 0; i < OBJ_COUNT; i++) begin
            for (int k = 0; k < LOAD_LANES; k++) begin
              if (int'(base_q) + k == i)
                objects_d[i*OBJ_WIDTH +: OBJ_WIDTH] = load_object_data_in[k*OBJ_WIDTH +: OBJ_WIDTH];
            end
          end
          if (int'(base_q) + LOAD_LANES >= OBJ_COUNT) begin
            state_d    = S_COLLISION;
            coll_req_d = 1'b1;
          end else begin
            base_d     = base_q + 11'(LOAD_LANES);
            lat_d      = 4'(MEM_LATENCY);
            load_sig_d = lane_strobes(base_q + 11'(LOAD_LANES));
            load_idx_d = lane_indices(base_q + 11'(LOAD_LANES));
          end
        end
      end

      S_COLLISION: begin
        if (coll_ack_in) begin
          // A zero collision time would stall the frame, so at least one tick.
          dt_floor = (coll_dt_in == '0) ? TIME_ONE : coll_dt_in;
          if (iter_q == 8'(MAX_ITER - 1)) step = left_q;
          else                            step = (dt_floor < left_q) ? dt_floor : left_q;
          upd_dt_d    = step;
          upd_start_d = 1'b1;
          coll_req_d  = 1'b0;
          state_d     = S_UPDATING;
        end
      end

      S_UPDATING: begin
        if (upd_done_in && !upd_start_q) begin
          objects_d = upd_objects_in;
          left_next = left_q - upd_dt_q;
          left_d    = left_next;
          iter_d    = (iter_q == 8'hFF) ? iter_q : iter_q + 8'd1;
          upd_dt_d  = '0;
          if (left_next == '0) begin
            state_d    = S_SAVING;
            save_ptr_d = '0;
            save_emit  = 1'b1;
          end else begin
            state_d    = S_COLLISION;
            coll_req_d = 1'b1;
          end
        end
      end

      S_SAVING: begin
        if (save_ptr_q == 10'(OBJ_COUNT - 1)) begin
          state_d     = S_IDLE;
          frame_end_d = 1'b1;
        end else begin
          save_ptr_d = save_ptr_q + 10'd1;
          save_emit  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Save outputs are registered, so they are computed from the register file
    // as it will be after this edge (matters for index 0 right after an update).
    if (save_emit) begin
      for (int i = 0; i < OBJ_COUNT; i++) begin
        if (save_ptr_d == 10'(i)) save_rec = objects_d[i*OBJ_WIDTH +: OBJ_WIDTH];
      end
      if (!save_rec[STATIC_BIT]) begin
        save_sig_d  = 1'b1;
        save_idx_d  = save_ptr_d;
        save_data_d = save_rec;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      left_q      <= '0;
      iter_q      <= '0;
      base_q      <= '0;
      lat_q       <= '0;
      objects_q   <= '0;
      load_sig_q  <= '0;
      load_idx_q  <= '0;
      coll_req_q  <= 1'b0;
      upd_start_q <= 1'b0;
      upd_dt_q    <= '0;
      save_ptr_q  <= '0;
      save_sig_q  <= 1'b0;
      save_idx_q  <= '0;
      save_data_q <= '0;
      frame_end_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      iter_q      <= iter_d;
      base_q      <= base_d;
      lat_q       <= lat_d;
      objects_q   <= objects_d;
      load_sig_q  <= load_sig_d;
      load_idx_q  <= load_idx_d;
      coll_req_q  <= coll_req_d;
      upd_start_q <= upd_start_d;
      upd_dt_q    <= upd_dt_d;
      save_ptr_q  <= save_ptr_d;
      save_sig_q  <= save_sig_d;
      save_idx_q  <= save_idx_d;
      save_data_q <= save_data_d;
      frame_end_q <= frame_end_d;
      overrun_q   <= overrun_d;
    end
  end

  assign state_out             = state_q;
  assign frame_end_out         = frame_end_q;
  assign overrun_out           = overrun_q;
  assign iter_count_out        = iter_q;
  assign load_signal_out       = load_sig_q;
  assign load_object_index_out = load_idx_q;
  assign coll_req_out          = coll_req_q;
  assign objects_out           = objects_q;
  assign upd_start_out         = upd_start_q;
  assign upd_dt_out            = upd_dt_q;
  assign save_signal_out       = save_sig_q;
  assign save_object_index_out = save_idx_q;
  assign save_object_data_out  = save_data_q;

endmodule

// File: tb/tb_phys_frame_controller.sv
// Testbench for phys_frame_controller: random memory contents, collision times
// and handshake delays, checked against a frame-level model of time budgeting.
module tb_phys_frame_controller;
  localparam int OBJ_COUNT   = 6;
  localparam int OBJ_WIDTH   = 40;
  localparam int LOAD_LANES  = 4;
  localparam int MEM_LATENCY = 2;
  localparam int MAX_ITER    = 4;
  localparam int TIME_W      = 32;
  localparam int TIME_DEC    = 11;
  localparam int STATIC_BIT  = 0;
  localparam int NB          = (OBJ_COUNT + LOAD_LANES - 1) / LOAD_LANES;
  localparam logic [31:0] FRAME_T = 32'd1 << TIME_DEC;

  // ---------------- clock / reset / DUT ----------------
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b1;
  logic frame_start_in = 1'b0;
  logic coll_ack_in = 1'b0;
  logic upd_done_in = 1'b0;
  logic [TIME_W-1:0] coll_dt_in = '0;
  logic [LOAD_LANES*OBJ_WIDTH-1:0] load_object_data_in = '0;
  logic [OBJ_COUNT*OBJ_WIDTH-1:0] upd_objects_in = '0;
  logic [2:0] state_out;
  logic frame_end_out, overrun_out, coll_req_out, upd_start_out, save_signal_out;
  logic [7:0] iter_count_out;
  logic [LOAD_LANES-1:0] load_signal_out;
  logic [LOAD_LANES*10-1:0] load_object_index_out;
  logic [OBJ_COUNT*OBJ_WIDTH-1:0] objects_out;
  logic [TIME_W-1:0] upd_dt_out;
  logic [9:0] save_object_index_out;
  logic [OBJ_WIDTH-1:0] save_object_data_out;

  always #5 sys_clk = ~sys_clk;

  phys_frame_controller #(
    .OBJ_COUNT(OBJ_COUNT), .OBJ_WIDTH(OBJ_WIDTH), .LOAD_LANES(LOAD_LANES),
    .MEM_LATENCY(MEM_LATENCY), .MAX_ITER(MAX_ITER), .TIME_W(TIME_W),
    .TIME_DEC(TIME_DEC), .STATIC_BIT(STATIC_BIT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_start_in(frame_start_in),
    .state_out(state_out), .frame_end_out(frame_end_out), .overrun_out(overrun_out),
    .iter_count_out(iter_count_out), .load_signal_out(load_signal_out),
    .load_object_index_out(load_object_index_out), .load_object_data_in(load_object_data_in),
    .coll_req_out(coll_req_out), .coll_ack_in(coll_ack_in), .coll_dt_in(coll_dt_in),
    .objects_out(objects_out), .upd_start_out(upd_start_out), .upd_dt_out(upd_dt_out),
    .upd_done_in(upd_done_in), .upd_objects_in(upd_objects_in),
    .save_signal_out(save_signal_out), .save_object_index_out(save_object_index_out),
    .save_object_data_out(save_object_data_out)
  );

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  int frame_ends = 0;
  logic [LOAD_LANES+LOAD_LANES*10-1:0] exp_load_q[$];
  logic [31:0] exp_step_q[$];
  logic [OBJ_WIDTH+10:0] exp_save_q[$];
  logic [7:0] exp_end_q[$];
  logic [31:0] act_steps[$];

  // Reference model of the frame
  logic [OBJ_WIDTH-1:0] mem [OBJ_COUNT];
  logic [31:0] m_left, m_step;
  int m_iter;

  // Stimulus modes
  int dt_mode = 0;          // 0: constant dt_const, 1: random
  logic [31:0] dt_const = 0;
  int ack_delay = -1;       // <0: random 0..3
  bit force_static = 0;     // objects 1 and 3 static, the rest dynamic

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [OBJ_WIDTH-1:0] rand_obj();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[OBJ_WIDTH-1:0];
  endfunction

  // ---------------- memory model (BRAM with MEM_LATENCY) ----------------
  initial begin : mem_model
    int due_q[$];
    logic [LOAD_LANES-1:0] sig_q[$];
    logic [LOAD_LANES*10-1:0] idx_q[$];
    logic [LOAD_LANES-1:0] s;
    logic [LOAD_LANES*10-1:0] ix;
    forever begin
      @(negedge sys_clk);
      for (int k = 0; k < LOAD_LANES; k++) load_object_data_in[k*OBJ_WIDTH +: OBJ_WIDTH] = rand_obj();
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        s = sig_q.pop_front();
        ix = idx_q.pop_front();
        for (int k = 0; k < LOAD_LANES; k++)
          if (s[k]) load_object_data_in[k*OBJ_WIDTH +: OBJ_WIDTH] = mem[int'(ix[k*10 +: 10]) % OBJ_COUNT];
      end
      if (!sys_rst_n) begin
        due_q.delete(); sig_q.delete(); idx_q.delete();
      end else if (load_signal_out != '0) begin
        due_q.push_back(cyc + MEM_LATENCY);
        sig_q.push_back(load_signal_out);
        idx_q.push_back(load_object_index_out);
      end
    end
  end

  // ---------------- collision engine driver ----------------
  initial begin : coll_driver
    int d;
    logic [31:0] dt;
    longint lt;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && coll_req_out) begin
        d = (ack_delay < 0) ? $urandom_range(0, 3) : ack_delay;
        for (int i = 0; i < d; i++) begin
          @(negedge sys_clk);
          // a stray update-done while the query is pending must be ignored
          upd_done_in = (i == 0);
          if (i == 0) for (int o = 0; o < OBJ_COUNT; o++) upd_objects_in[o*OBJ_WIDTH +: OBJ_WIDTH] = rand_obj();
          if (sys_rst_n) check("coll_req_held", coll_req_out, 1);
        end
        dt = (dt_mode == 0) ? dt_const : $urandom_range(0, 3000);
        upd_done_in = 1'b0;
        coll_ack_in = 1'b1;
        coll_dt_in = dt;
        lt = longint'(dt);
        if (lt < 1) lt = 1;
        if (lt > longint'(m_left)) lt = longint'(m_left);
        if (m_iter == MAX_ITER - 1) lt = longint'(m_left);
        m_step = 32'(lt);
        exp_step_q.push_back(m_step);
        @(negedge sys_clk);
        coll_ack_in = 1'b0;
        coll_dt_in = $urandom;
        if (sys_rst_n) begin
          check("coll_req_drop", coll_req_out, 0);
          check("coll_to_upd", state_out, 3);
        end
      end
    end
  end

  // ---------------- update engine driver ----------------
  initial begin : upd_driver
    int d;
    logic [OBJ_WIDTH-1:0] nobj [OBJ_COUNT];
    logic sig;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && upd_start_out) begin
        d = $urandom_range(2, 3);
        for (int i = 0; i < d; i++) begin
          @(negedge sys_clk);
          // a stray collision ack during the update must be ignored
          coll_ack_in = (i == 0);
          if (i == 0) coll_dt_in = $urandom;
        end
        coll_ack_in = 1'b0;
        for (int o = 0; o < OBJ_COUNT; o++) begin
          nobj[o] = rand_obj();
          if (force_static) nobj[o][STATIC_BIT] = (o == 1 || o == 3);
          upd_objects_in[o*OBJ_WIDTH +: OBJ_WIDTH] = nobj[o];
        end
        upd_done_in = 1'b1;
        if (sys_rst_n) begin
          m_left = m_left - m_step;
          m_iter = (m_iter < 255) ? m_iter + 1 : 255;
          if (m_left == 0) begin
            for (int o = 0; o < OBJ_COUNT; o++) begin
              sig = !nobj[o][STATIC_BIT];
              exp_save_q.push_back({sig, sig ? 10'(o) : 10'd0, sig ? nobj[o] : {OBJ_WIDTH{1'b0}}});
            end
            exp_end_q.push_back(8'(m_iter));
          end
        end
        @(negedge sys_clk);
        upd_done_in = 1'b0;
        if (sys_rst_n) begin
          for (int o = 0; o < OBJ_COUNT; o++)
            check("upd_obj", objects_out[o*OBJ_WIDTH +: OBJ_WIDTH], nobj[o]);
          check("upd_next_state", state_out, (m_left == 0) ? 3'd4 : 3'd2);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [2:0] prev_state;
    int last_issue;
    logic [LOAD_LANES+LOAD_LANES*10-1:0] el;
    logic [OBJ_WIDTH+10:0] es;
    prev_state = 3'd0;
    last_issue = 0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        prev_state = 3'd0;
      end else begin
        if (load_signal_out != '0) begin
          if (exp_load_q.size() == 0) check("load_unexpected", 64'(load_signal_out), 0);
          else begin
            el = exp_load_q.pop_front();
            check("load_strobe", 64'(load_signal_out), 64'(el[LOAD_LANES+LOAD_LANES*10-1 -: LOAD_LANES]));
            check("load_index", 64'(load_object_index_out), 64'(el[LOAD_LANES*10-1:0]));
            if (prev_state == 3'd1) check("load_gap", 64'(cyc - last_issue), MEM_LATENCY + 1);
          end
          last_issue = cyc;
        end
        if (prev_state == 3'd1 && state_out == 3'd2)
          for (int i = 0; i < OBJ_COUNT; i++)
            check("load_obj", objects_out[i*OBJ_WIDTH +: OBJ_WIDTH], mem[i]);
        if (upd_start_out) begin
          act_steps.push_back(upd_dt_out);
          if (exp_step_q.size() == 0) check("upd_unexpected", 1, 0);
          else check("upd_dt", upd_dt_out, exp_step_q.pop_front());
        end
        if (state_out == 3'd4) begin
          if (exp_save_q.size() == 0) check("save_unexpected", 1, 0);
          else begin
            es = exp_save_q.pop_front();
            check("save_sig", save_signal_out, es[OBJ_WIDTH+10]);
            check("save_idx", save_object_index_out, es[OBJ_WIDTH+9 -: 10]);
            check("save_data", save_object_data_out, es[OBJ_WIDTH-1:0]);
          end
        end else if (save_signal_out) begin
          check("save_outside", 1, 0);
        end
        if (frame_end_out) begin
          frame_ends++;
          check("end_state", state_out, 0);
          check("end_save_left", exp_save_q.size(), 0);
          if (exp_end_q.size() == 0) check("end_unexpected", 1, 0);
          else check("end_iter", iter_count_out, exp_end_q.pop_front());
        end
        prev_state = state_out;
      end
    end
  end

  // ---------------- sequencing tasks ----------------
  task automatic prepare_frame();
    logic [LOAD_LANES-1:0] s;
    logic [LOAD_LANES*10-1:0] ix;
    int o;
    for (int i = 0; i < OBJ_COUNT; i++) mem[i] = rand_obj();
    m_left = FRAME_T;
    m_iter = 0;
    act_steps.delete();
    for (int b = 0; b < NB; b++) begin
      s = '0;
      ix = '0;
      for (int k = 0; k < LOAD_LANES; k++) begin
        o = b * LOAD_LANES + k;
        if (o < OBJ_COUNT) begin
          s[k] = 1'b1;
          ix[k*10 +: 10] = 10'(o);
        end
      end
      exp_load_q.push_back({s, ix});
    end
  endtask

  task automatic start_frame();
    prepare_frame();
    @(posedge sys_clk); #1 frame_start_in = 1'b1;
    @(posedge sys_clk); #1 frame_start_in = 1'b0;
    @(negedge sys_clk);
    check("start_state", state_out, 1);
    check("start_overrun", overrun_out, 0);
  endtask

  task automatic wait_frame_end(input int budget);
    int n = 0;
    int prev = frame_ends;
    while (frame_ends == prev && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (frame_ends == prev) check("frame_timeout", 1, 0);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (state_out !== s && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (state_out !== s) check(name, state_out, s);
  endtask

  task automatic check_steps(input int n, input int s0, input int s1, input int s2, input int s3);
    int e [4];
    e = '{s0, s1, s2, s3};
    check("step_count", act_steps.size(), n);
    for (int i = 0; i < n && i < act_steps.size(); i++) check("step_value", act_steps[i], e[i]);
  endtask

  task automatic post_frame(input int exp_iter, input int ends_before);
    repeat (5) @(negedge sys_clk);
    check("ends_per_frame", frame_ends - ends_before, 1);
    check("idle_state", state_out, 0);
    check("iter_hold", iter_count_out, exp_iter);
    check("loads_left", exp_load_q.size(), 0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_state"}, state_out, 0);
    check({tag, "_frame_end"}, frame_end_out, 0);
    check({tag, "_overrun"}, overrun_out, 0);
    check({tag, "_iter"}, iter_count_out, 0);
    check({tag, "_load_sig"}, 64'(load_signal_out), 0);
    check({tag, "_load_idx"}, 64'(load_object_index_out), 0);
    check({tag, "_coll_req"}, coll_req_out, 0);
    check({tag, "_objects_zero"}, objects_out == '0, 1);
    check({tag, "_upd_start"}, upd_start_out, 0);
    check({tag, "_upd_dt"}, upd_dt_out, 0);
    check({tag, "_save_sig"}, save_signal_out, 0);
    check({tag, "_save_idx"}, save_object_index_out, 0);
    check({tag, "_save_data"}, save_object_data_out, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int e0;
    #1 sys_rst_n = 1'b0;
    #1 reset_checks("por");
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Constant dt=768: 768, 768, then the remaining 512
    dt_mode = 0; dt_const = 768; ack_delay = -1; force_static = 0;
    e0 = frame_ends;
    start_frame();
    wait_frame_end(500);
    check_steps(3, 768, 768, 512, 0);
    post_frame(3, e0);

    // dt=1: last allowed iteration takes the rest
    dt_const = 1;
    e0 = frame_ends;
    start_frame();
    wait_frame_end(500);
    check_steps(4, 1, 1, 1, 2045);
    post_frame(4, e0);

    // dt=0 is floored to 1; ack held off for 5 cycles
    dt_const = 0; ack_delay = 5;
    e0 = frame_ends;
    start_frame();
    wait_frame_end(500);
    check_steps(4, 1, 1, 1, 2045);
    post_frame(4, e0);

    // Static objects skipped on save; start request during SAVING is an overrun
    dt_mode = 1; ack_delay = -1; force_static = 1;
    e0 = frame_ends;
    start_frame();
    wait_state(3'd4, 500, "reach_saving");
    frame_start_in = 1'b1;
    @(negedge sys_clk);
    frame_start_in = 1'b0;
    check("overrun_pulse", overrun_out, 1);
    check("no_restart", state_out, 4);
    @(negedge sys_clk);
    check("overrun_single", overrun_out, 0);
    wait_frame_end(100);
    post_frame(m_iter, e0);

    // Random frames
    for (int f = 0; f < 6; f++) begin
      force_static = $urandom_range(0, 1);
      e0 = frame_ends;
      start_frame();
      wait_frame_end(500);
      post_frame(m_iter, e0);
    end

    // Reset in the middle of an update, then a normal frame
    force_static = 0;
    start_frame();
    wait_state(3'd3, 500, "reach_updating");
    #2 sys_rst_n = 1'b0;
    #1 reset_checks("mid_rst");
    repeat (6) @(negedge sys_clk);
    exp_load_q.delete(); exp_step_q.delete(); exp_save_q.delete(); exp_end_q.delete();
    e0 = frame_ends;
    prepare_frame();
    sys_rst_n = 1'b1;
    frame_start_in = 1'b1;
    @(posedge sys_clk); #1 frame_start_in = 1'b0;
    @(negedge sys_clk);
    check("start_after_reset", state_out, 1);
    wait_frame_end(500);
    post_frame(m_iter, e0);

    check("final_step_q", exp_step_q.size(), 0);
    check("final_save_q", exp_save_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
